// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum
// Purpose  : Saturating packet accumulator for 8-bit multiplier products.
//            Beats are summed until a last-flagged beat or MAX_TERMS beats;
//            the packet result is then held in a one-entry output register
//            with valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module prod_accum #(
  parameter int PW        = 8,   // product width
  parameter int AW        = 16,  // accumulator / sum width, AW >= PW
  parameter int MAX_TERMS = 16   // forced packet close, 1..255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [7:0]    out_count,
  output logic          out_ovf
);

  localparam logic [AW-1:0] C_SAT_VALUE = '1;
  localparam logic [7:0]    C_MAX_TERMS = 8'(MAX_TERMS);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Running packet state; always zero at the start of a packet because it is
  // cleared on the same edge that closes the previous packet.
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;

  // Held result
  logic [AW-1:0] r_out_sum;
  logic [AW-1:0] w_out_sum_nxt;
  logic [7:0]    r_out_count;
  logic [7:0]    w_out_count_nxt;
  logic          r_out_ovf;
  logic          w_out_ovf_nxt;

  // Per-beat arithmetic
  logic [AW:0]   w_prod_ext;
  logic [AW:0]   w_add;
  logic          w_sat;
  logic [AW-1:0] w_beat_acc;
  logic [7:0]    w_beat_cnt;
  logic          w_close;
  logic          w_take;

  // One extra bit catches the carry out of the accumulator
  assign w_prod_ext = {{(AW + 1 - PW){1'b0}}, in_prod};
  assign w_add      = {1'b0, r_acc} + w_prod_ext;
  assign w_sat      = w_add[AW] | r_ovf;
  assign w_beat_acc = w_sat ? C_SAT_VALUE : w_add[AW-1:0];
  assign w_beat_cnt = r_cnt + 8'd1;
  assign w_close    = in_last | (w_beat_cnt == C_MAX_TERMS);

  // Ready depends only on registered state and the downstream ready, so a
  // held result that is being emitted frees the slot in the same cycle.
  assign in_ready   = (r_state == ACC) | out_ready;
  assign w_take     = in_valid & in_ready;

  assign out_valid  = (r_state == HOLD);
  assign out_sum    = r_out_sum;
  assign out_count  = r_out_count;
  assign out_ovf    = r_out_ovf;

  // Next-state and datapath update for ACC/HOLD, defaults hold every register
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;

    // Held result leaves with nothing new arriving
    if ((r_state == HOLD) && out_ready && !w_take) begin
      w_state_nxt = ACC;
    end

    if (w_take) begin
      if (w_close) begin
        // Closing beat: publish post-beat values, restart the packet state
        w_state_nxt     = HOLD;
        w_out_sum_nxt   = w_beat_acc;
        w_out_count_nxt = w_beat_cnt;
        w_out_ovf_nxt   = w_sat;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_nxt       = 1'b0;
      end else begin
        // Also covers an emit-and-accept in HOLD: packet state is zero there
        w_state_nxt     = ACC;
        w_acc_nxt       = w_beat_acc;
        w_cnt_nxt       = w_beat_cnt;
        w_ovf_nxt       = w_sat;
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator and result registers; reset discards partial and held data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

endmodule
`default_nettype wire
